uart_tx_fifo: RTL and testbench

//  8N1 UART transmitter with an internal byte FIFO; the transmit-side counterpart
//  of the command receiver that drives the RGB LEDs. Control logic pushes reply or

---
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-push and serial-status signals between control logic (master) and the
// UART transmitter (slave).
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic               wr_valid;
  logic [7:0]         wr_data;
  logic               wr_ready;
  logic               uarttx;
  logic               busy;
  logic [FIFO_AW:0]   fifo_count;
  logic               overflow;

  modport master (
    output wr_valid, wr_data,
    input  wr_ready, uarttx, busy, fifo_count, overflow
  );

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, uarttx, busy, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a 2**FIFO_AW byte FIFO; back-to-back frames are
// sent with no idle gap while bytes remain queued.
module uart_tx_fifo #(
  parameter int CLK_DIV = 1250,
  parameter int FIFO_AW = 4
) (
  input  logic           hw_clk,
  input  logic           resetn,
  uart_tx_fifo_if.slave  bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0]    BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q;
  logic [BW-1:0]        baud_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 ovf_q;
  logic [FIFO_AW-1:0]   wr_ptr_q;
  logic [FIFO_AW-1:0]   rd_ptr_q;
  logic [FIFO_AW:0]     count_q;
  logic [FIFO_AW:0]     count_d;
  logic [7:0]           mem_q [DEPTH];

  logic wr_ready;
  logic push;
  logic pop;
  logic not_empty;
  logic bit_end;

  assign wr_ready  = (count_q != FULL_CNT);
  assign push      = bus.wr_valid & wr_ready;
  assign not_empty = (count_q != '0);
  assign bit_end   = (baud_q == BAUD_LAST);
  // Pops only from the registered count, so a byte is never sent on its push edge.
  assign pop       = not_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge hw_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (bus.wr_valid && !wr_ready) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      baud_q <= ((state_q == IDLE) || bit_end) ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
        STOP: begin
          // Chain straight into the next start bit when another byte is waiting.
          if (bit_end) begin
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.uarttx     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table for a single frame,
// then logged-waveform decoding for back-to-back, overflow, wrap, reset and full-rate cases.
module tb_uart_tx_fifo;
  logic hw_clk = 1'b0;
  logic resetn;
  always #5 hw_clk = ~hw_clk;

  uart_tx_fifo_if #(.FIFO_AW(4)) bus ();
  uart_tx_fifo_if #(.FIFO_AW(4)) sbus ();

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_AW(4)) u_dut (
    .hw_clk (hw_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  uart_tx_fifo #(.CLK_DIV(1250), .FIFO_AW(4)) u_slow (
    .hw_clk (hw_clk),
    .resetn (resetn),
    .bus    (sbus)
  );

  int total = 0;
  int bad   = 0;

  logic       log_en  = 1'b0;
  logic       log_sel = 1'b0;
  logic       txlog[$];
  logic       busylog[$];
  logic [7:0] expq[$];

  always @(negedge hw_clk) begin
    if (log_en) begin
      txlog.push_back(log_sel ? sbus.uarttx : bus.uarttx);
      busylog.push_back(log_sel ? sbus.busy : bus.busy);
    end
  end

  typedef struct {
    logic       vld;
    logic [7:0] data;
    int         adv;
    logic       tx;
    logic       busy;
    int         cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got missing expected present", name);
  endtask

  task automatic do_reset();
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 8'h00;
    sbus.wr_valid = 1'b0;
    sbus.wr_data  = 8'h00;
    resetn = 1'b0;
    repeat (2) @(posedge hw_clk);
    @(negedge hw_clk);
    resetn = 1'b1;
    repeat (2) @(negedge hw_clk);
  endtask

  task automatic start_log(input logic sel);
    txlog.delete();
    busylog.delete();
    log_sel = sel;
    log_en  = 1'b1;
  endtask

  function automatic int find_start();
    for (int i = 0; i < txlog.size(); i++)
      if (txlog[i] === 1'b0) return i;
    return -1;
  endfunction

  // Frames are decoded at fixed offsets from the first start bit, so any idle
  // gap between frames shows up as a bad start/stop bit or busy drop.
  task automatic check_frames(input string name, input int div);
    int s, base, stop_at, lows;
    logic [9:0] fr;
    s = find_start();
    if (s < 0) begin
      fail_now({name, " start bit"});
      return;
    end
    for (int f = 0; f < expq.size(); f++) begin
      base = s + f * 10 * div;
      if (base + 10 * div > txlog.size()) begin
        fail_now({name, " frame in log"});
        return;
      end
      for (int j = 0; j < 10; j++) fr[j] = txlog[base + j * div + div / 2];
      check($sformatf("%s frame%0d", name, f), {22'd0, fr}, {22'd0, 1'b1, expq[f], 1'b0});
    end
    stop_at = s + expq.size() * 10 * div;
    lows = 0;
    for (int i = s; i < stop_at; i++) if (busylog[i] !== 1'b1) lows++;
    check({name, " busy gaps"}, lows, 0);
    if (stop_at < busylog.size()) check({name, " busy end"}, {31'd0, busylog[stop_at]}, 0);
    else fail_now({name, " busy end in log"});
  endtask

  initial begin
    int k, cyc, s, rise;

    // Frame of 0x55 sampled at chosen cycles after the push edge.
    vecs.push_back('{1'b1, 8'h55, 1, 1'b1, 1'b0, 1});
    vecs.push_back('{1'b0, 8'h00, 1, 1'b0, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 3, 1'b0, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 1, 1'b1, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 3, 1'b1, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 1, 1'b0, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b1, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 4, 1'b0, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 3, 1'b0, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 1, 1'b1, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 3, 1'b1, 1'b1, 0});
    vecs.push_back('{1'b0, 8'h00, 1, 1'b1, 1'b0, 0});

    do_reset();
    check("rst uarttx",   {31'd0, bus.uarttx},   1);
    check("rst busy",     {31'd0, bus.busy},     0);
    check("rst count",    {27'd0, bus.fifo_count}, 0);
    check("rst wr_ready", {31'd0, bus.wr_ready}, 1);
    check("rst overflow", {31'd0, bus.overflow}, 0);
    check("rst slow uarttx", {31'd0, sbus.uarttx}, 1);

    // Test 1: single 0x55 frame
    for (int v = 0; v < vecs.size(); v++) begin
      bus.wr_valid = vecs[v].vld;
      bus.wr_data  = vecs[v].data;
      for (int a = 0; a < vecs[v].adv; a++) begin
        @(posedge hw_clk);
        #1 bus.wr_valid = 1'b0;
      end
      check($sformatf("t1 row%0d uarttx", v), {31'd0, bus.uarttx}, {31'd0, vecs[v].tx});
      check($sformatf("t1 row%0d busy", v),   {31'd0, bus.busy},   {31'd0, vecs[v].busy});
      check($sformatf("t1 row%0d count", v),  {27'd0, bus.fifo_count}, vecs[v].cnt);
    end

    // Test 2: three bytes on consecutive cycles, zero-gap frames
    do_reset();
    start_log(1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h41;
    @(posedge hw_clk); #1 bus.wr_data = 8'h42;
    @(posedge hw_clk); #1 bus.wr_data = 8'h43;
    @(posedge hw_clk); #1 bus.wr_valid = 1'b0;
    repeat (130) @(posedge hw_clk);
    log_en = 1'b0;
    expq = '{8'h41, 8'h42, 8'h43};
    check_frames("t2", 4);

    // Test 3: overflow while transmitting
    do_reset();
    start_log(1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA0;
    @(posedge hw_clk); #1 bus.wr_valid = 1'b0;
    repeat (2) @(posedge hw_clk);
    #1;
    for (int j = 0; j < 17; j++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hB0 + 8'(j);
      @(posedge hw_clk);
      #1;
      if (j == 14) begin
        check("t3 count15", {27'd0, bus.fifo_count}, 15);
        check("t3 ready15", {31'd0, bus.wr_ready}, 1);
      end
      if (j == 15) begin
        check("t3 count16", {27'd0, bus.fifo_count}, 16);
        check("t3 ready16", {31'd0, bus.wr_ready}, 0);
        check("t3 ovf16",   {31'd0, bus.overflow}, 0);
      end
    end
    bus.wr_valid = 1'b0;
    check("t3 count17", {27'd0, bus.fifo_count}, 16);
    check("t3 ovf17",   {31'd0, bus.overflow}, 1);
    repeat (720) @(posedge hw_clk);
    log_en = 1'b0;
    expq = '{8'hA0};
    for (int j = 0; j < 16; j++) expq.push_back(8'hB0 + 8'(j));
    check_frames("t3", 4);
    check("t3 ovf sticky", {31'd0, bus.overflow}, 1);
    check("t3 count end",  {27'd0, bus.fifo_count}, 0);

    // Test 4: 40 bytes through the FIFO, pointer wrap
    do_reset();
    start_log(1'b0);
    k = 0;
    cyc = 0;
    while (k < 40 && cyc < 3000) begin
      @(negedge hw_clk);
      bus.wr_valid = bus.wr_ready;
      bus.wr_data  = 8'(k);
      if (bus.wr_ready) k++;
      cyc++;
    end
    @(negedge hw_clk);
    bus.wr_valid = 1'b0;
    check("t4 pushes", k, 40);
    repeat (1700) @(posedge hw_clk);
    log_en = 1'b0;
    expq.delete();
    for (int j = 0; j < 40; j++) expq.push_back(8'(j));
    check_frames("t4", 4);
    check("t4 overflow", {31'd0, bus.overflow}, 0);

    // Test 5: reset in the middle of data bit 3 with 5 bytes queued
    do_reset();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hF7;
    for (int j = 0; j < 6; j++) begin
      @(posedge hw_clk);
      #1 bus.wr_data = 8'h11 + 8'(j);
    end
    bus.wr_valid = 1'b0;
    repeat (14) @(posedge hw_clk);
    @(negedge hw_clk);
    check("t5 pre busy",   {31'd0, bus.busy},   1);
    check("t5 pre count",  {27'd0, bus.fifo_count}, 5);
    check("t5 pre uarttx", {31'd0, bus.uarttx}, 0);
    resetn = 1'b0;
    #1;
    check("t5 rst uarttx", {31'd0, bus.uarttx}, 1);
    check("t5 rst busy",   {31'd0, bus.busy},   0);
    check("t5 rst count",  {27'd0, bus.fifo_count}, 0);
    check("t5 rst ready",  {31'd0, bus.wr_ready}, 1);
    @(negedge hw_clk);
    resetn = 1'b1;
    start_log(1'b0);
    repeat (100) @(posedge hw_clk);
    log_en = 1'b0;
    k = 0;
    for (int i = 0; i < txlog.size(); i++) if (txlog[i] !== 1'b1 || busylog[i] !== 1'b0) k++;
    check("t5 silent after reset", k, 0);

    // Test 6: full-rate divider, 0xA5
    do_reset();
    start_log(1'b1);
    sbus.wr_valid = 1'b1;
    sbus.wr_data  = 8'hA5;
    @(posedge hw_clk); #1 sbus.wr_valid = 1'b0;
    repeat (12600) @(posedge hw_clk);
    log_en = 1'b0;
    s = find_start();
    rise = -1;
    if (s >= 0)
      for (int i = s; i < txlog.size(); i++)
        if (txlog[i] === 1'b1) begin
          rise = i - s;
          break;
        end
    check("t6 start bit length", rise, 1250);
    expq = '{8'hA5};
    check_frames("t6", 1250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
